// File: rtl/cdc_fifo_read_drain_if.sv
// FIFO read port plus downstream valid/ready stream used by cdc_fifo_read_drain.
// The drain is the master: it drives the pop request and the outgoing stream.
interface cdc_fifo_read_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_read_data;
  logic                  fifo_read_enable;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  fifo_empty, fifo_read_data, out_ready,
    output fifo_read_enable, out_data, out_valid
  );

  modport slave (
    output fifo_empty, fifo_read_data, out_ready,
    input  fifo_read_enable, out_data, out_valid
  );
endinterface

// File: rtl/cdc_fifo_read_drain.sv
// Read-side consumer for cdc_fifo: pops words, absorbs the 1-cycle read latency in a
// 2-entry skid buffer, streams them out, and supports a drain-and-discard flush.
module cdc_fifo_read_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int DROP_WIDTH = 8
) (
  input  logic                  read_clk,
  input  logic                  read_rst,
  input  logic                  enable,
  input  logic                  flush,
  cdc_fifo_read_drain_if.master bus,
  output logic                  flush_done,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [DROP_WIDTH-1:0] drop_count
);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] skid_q [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            occ_q;
  logic                  inflight_q;
  logic                  flush_done_q;
  logic [CNT_WIDTH-1:0]  word_count_q;
  logic [DROP_WIDTH-1:0] drop_count_q;

  logic                  in_flush;
  logic                  flush_req;
  logic                  out_valid;
  logic                  pop;
  logic                  issue;
  logic [2:0]            pending;
  logic [1:0]            drop_n;
  logic [DROP_WIDTH:0]   drop_sum;
  logic [DROP_WIDTH-1:0] drop_count_d;

  assign in_flush  = (state_q == FLUSH);
  assign flush_req = !in_flush && flush;
  // A flush request wins over a handshake in the same cycle, so hide the head word.
  assign out_valid = !in_flush && !flush && (occ_q != 2'd0);
  assign pop       = out_valid && bus.out_ready;
  assign pending   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    issue = 1'b0;
    if (read_rst) begin
      issue = 1'b0;
    end else if (in_flush) begin
      issue = !bus.fifo_empty;
    end else begin
      issue = enable && !bus.fifo_empty && !flush && (pending < 3'd2);
    end
  end

  always_comb begin
    drop_n = 2'd0;
    if (flush_req) begin
      drop_n = occ_q + {1'b0, inflight_q};
    end else if (in_flush) begin
      drop_n = {1'b0, inflight_q};
    end
  end

  assign drop_sum     = {1'b0, drop_count_q} + {{(DROP_WIDTH-1){1'b0}}, drop_n};
  assign drop_count_d = drop_sum[DROP_WIDTH] ? {DROP_WIDTH{1'b1}} : drop_sum[DROP_WIDTH-1:0];

  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      state_q      <= IDLE;
      skid_q[0]    <= '0;
      skid_q[1]    <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      flush_done_q <= 1'b0;
      word_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      flush_done_q <= 1'b0;
      drop_count_q <= drop_count_d;
      inflight_q   <= issue;
      if (pop) begin
        word_count_q <= word_count_q + 1'b1;
      end
      case (state_q)
        IDLE, STREAM: begin
          if (flush) begin
            state_q  <= FLUSH;
            occ_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
          end else begin
            if (inflight_q) begin
              skid_q[wr_ptr_q] <= bus.fifo_read_data;
              wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
              rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= pending[1:0];
            if (issue) begin
              state_q <= STREAM;
            end else if ((occ_q == 2'd0) && !inflight_q) begin
              state_q <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (bus.fifo_empty && !inflight_q) begin
            flush_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fifo_read_enable = issue;
  assign bus.out_valid        = out_valid;
  assign bus.out_data         = out_valid ? skid_q[rd_ptr_q] : '0;
  assign flush_done           = flush_done_q;
  assign busy                 = (state_q != IDLE);
  assign word_count           = word_count_q;
  assign drop_count           = drop_count_q;
endmodule
